ref_setpoint_ctrl: RTL and testbench
====================================

REF_SETPOINT_CTRL -- requirements
Module: ref_setpoint_ctrl

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of independent setpoint channels (1..8).
REQ-002 SHALL provide parameter WIDTH, default 4, bit width of each channel value.
REQ-003 SHALL provide parameter MIN_VAL, default 0, lower bound of every channel value.
REQ-004 SHALL provide parameter MAX_VAL, default 9, upper bound of every channel value; MIN_VAL < MAX_VAL < 2^WIDTH.
REQ-005 SHALL provide parameter RST_VAL, default 0, reset value of every channel, within MIN_VAL..MAX_VAL.
REQ-006 SHALL provide parameter DIV, default 25000000, prescaler period in clk_i cycles (>= 2).
REQ-007 SHALL provide parameter WRAP, default 0, 0 = saturate at bounds, 1 = wrap at bounds.
REQ-008 SHALL provide parameter HOLD_TICKS, default 4, consecutive held ticks before fast stepping (only with HOLD_ACCEL_EN).
REQ-009 SHALL provide parameter FAST_STEP, default 3, step size once fast stepping is active (only with HOLD_ACCEL_EN).
REQ-010 SHALL provide port clk_i, input, 1, system clock.
REQ-011 SHALL provide port reset, input, 1, synchronous, active-high reset; clock is clk_i.
REQ-012 SHALL provide port up_i, input, 1, level request to increment the selected channel.
REQ-013 SHALL provide port down_i, input, 1, level request to decrement the selected channel.
REQ-014 SHALL provide port ch_sel_i, input, max(1,$clog2(NCH)), index of the channel being adjusted.
REQ-015 SHALL provide port value_o, output, NCH*WIDTH, all channel values; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-016 SHALL provide port sel_value_o, output, WIDTH, value of the channel addressed by ch_sel_i, combinational from registers.
REQ-017 SHALL provide port tick_o, output, 1, one-cycle pulse marking each prescaler update point.
REQ-018 SHALL provide ports at_max_o and at_min_o, outputs, NCH each, bit k high when channel k equals MAX_VAL / MIN_VAL.

Function
REQ-019 SHALL count a prescaler 0..DIV-1 on every clk_i edge, wrapping to 0; tick_o SHALL be high exactly in the cycle the count equals DIV-1.
REQ-020 SHALL sample up_i, down_i and ch_sel_i only in tick cycles; the channel update SHALL be visible on value_o the cycle after the tick.
REQ-021 SHALL leave all channels unchanged on a tick when up_i and down_i are both low or both high.
REQ-022 SHALL change only the selected channel; ch_sel_i >= NCH SHALL cause no change.
REQ-023 SHALL compute next value in WIDTH+1 bits so value+step never overflows before bound checking.
REQ-024 SHALL, with WRAP=0, clamp increments to MAX_VAL and decrements to MIN_VAL; a request at the bound is a no-op.
REQ-025 SHALL, with WRAP=1, load MIN_VAL on increment at exactly MAX_VAL and MAX_VAL on decrement at exactly MIN_VAL; otherwise step clamped to the bound.
REQ-026 SHALL use step 1 for all updates unless fast stepping is active per REQ-031.

Reset
REQ-027 SHALL, on reset high at a clk_i edge, clear the prescaler to 0, set every channel to RST_VAL, clear the hold counter, and drive tick_o low in the following cycle.
REQ-028 SHALL give reset priority over a coincident tick; no channel update occurs in that cycle.
REQ-029 SHALL hold at_max_o/at_min_o consistent with RST_VAL in the cycle after reset.

Configuration
REQ-030 SHALL compile hold acceleration only when macro HOLD_ACCEL_EN is defined.
REQ-031 SHALL, with HOLD_ACCEL_EN, count consecutive ticks with the same single direction and unchanged ch_sel_i; once count reaches HOLD_TICKS, use FAST_STEP; count saturates and clears on release, direction reversal, both pressed, or channel change.
REQ-032 SHALL, without HOLD_ACCEL_EN, contain no hold counter and always step by 1; HOLD_TICKS and FAST_STEP are ignored.

Verification (bench uses DIV=4, NCH=4, WIDTH=4, MIN=0, MAX=9, RST=0)
REQ-033 SHALL verify: reset, then up_i=1 ch 1 for 3 ticks -> channel 1 = 3, others 0, tick_o period 4 cycles.
REQ-034 SHALL verify: WRAP=0, channel 2 at 9, up_i held 2 ticks -> stays 9, at_max_o[2]=1; WRAP=1 -> 0 then 1.
REQ-035 SHALL verify: up_i and down_i both high 3 ticks on channel 0 = 5 -> remains 5.
REQ-036 SHALL verify: reset asserted in a tick cycle with up_i=1, channel 3 = 7 -> channel 3 = 0, no increment, prescaler restarts at 0.
REQ-037 SHALL verify with HOLD_ACCEL_EN, HOLD_TICKS=4, FAST_STEP=3: up held on ch 0 from 0 -> 1,2,3,4,7,9(clamped); release then up -> step 1.
REQ-038 SHALL verify: ch_sel_i=5 (out of range encoding on 3-bit select with NCH=4... n/a) substitute ch_sel_i switch mid-hold -> step reverts to 1 and only new channel changes.

Source files
------------

// File: rtl/ref_setpoint_ctrl.sv
// Purpose : multi-channel bounded setpoint register, stepped up/down on prescaler ticks.
// Latency : inputs sampled in the tick cycle; the new value shows on value_o one cycle later.
// Backpr. : none; level requests between ticks are ignored and nothing is queued.
//
// Ports:
//   clk_i, reset    clock and synchronous active-high reset
//   up_i, down_i    level step requests; both or neither pressed means no change
//   ch_sel_i        channel to adjust; out-of-range indices are ignored
//   value_o         all channels packed; channel k at [k*WIDTH +: WIDTH]
//   sel_value_o     value of the addressed channel (zero when the index is out of range)
//   tick_o          one-cycle pulse at each prescaler update point
//   at_max_o/min_o  per-channel bound flags
//
// Optional feature: define HOLD_ACCEL_EN to step by FAST_STEP once the same single
// direction on the same channel has been held for HOLD_TICKS consecutive ticks.
module ref_setpoint_ctrl #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 4,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 9,
  parameter int RST_VAL    = 0,
  parameter int DIV        = 25000000,
  parameter int WRAP       = 0,
  parameter int HOLD_TICKS = 4,
  parameter int FAST_STEP  = 3
) (
  input  logic                                    clk_i,
  input  logic                                    reset,
  input  logic                                    up_i,
  input  logic                                    down_i,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel_i,
  output logic [NCH*WIDTH-1:0]                    value_o,
  output logic [WIDTH-1:0]                        sel_value_o,
  output logic                                    tick_o,
  output logic [NCH-1:0]                          at_max_o,
  output logic [NCH-1:0]                          at_min_o
);

  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MIN_X    = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   FAST_X   = (WIDTH+1)'(FAST_STEP);

  // Elaboration-time sanity checks on the configuration.
  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("ref_setpoint_ctrl: NCH must be 1..8");
  end
  if (MIN_VAL >= MAX_VAL || MAX_VAL >= (1 << WIDTH)) begin : g_bad_bounds
    $error("ref_setpoint_ctrl: need MIN_VAL < MAX_VAL < 2**WIDTH");
  end
  if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("ref_setpoint_ctrl: RST_VAL outside MIN_VAL..MAX_VAL");
  end
  if (DIV < 2) begin : g_bad_div
    $error("ref_setpoint_ctrl: DIV must be >= 2");
  end
  if (HOLD_TICKS < 1 || FAST_STEP < 1 || FAST_STEP >= (1 << WIDTH)) begin : g_bad_hold
    $error("ref_setpoint_ctrl: HOLD_TICKS >= 1 and 1 <= FAST_STEP < 2**WIDTH required");
  end

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick   = (pre_cnt == PRE_LAST);
  assign tick_o = tick;

  always_ff @(posedge clk_i) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  // ----------------------------------------------------------- channel select
  logic sel_ok;
  logic single;

  assign single = up_i ^ down_i;

  // With a power-of-two channel count every select encoding is a real channel.
  if (NCH == (1 << SEL_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = ({1'b0, ch_sel_i} < (SEL_W+1)'(NCH));
  end

  // --------------------------------------------------------- hold acceleration
  logic fast;

`ifdef HOLD_ACCEL_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0]    hold_cnt;
  logic             hold_up;
  logic [SEL_W-1:0] hold_sel;
  logic             hold_same;

  // A tick continues the run only if the previous tick was a press in the same
  // direction on the same channel index.
  assign hold_same = (hold_cnt != '0) && (hold_up == up_i) && (hold_sel == ch_sel_i);
  assign fast      = hold_same && (hold_cnt >= HOLD_MAX);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      hold_cnt <= '0;
      hold_up  <= 1'b0;
      hold_sel <= '0;
    end else if (tick) begin
      if (!single) begin
        hold_cnt <= '0;
      end else begin
        hold_up  <= up_i;
        hold_sel <= ch_sel_i;
        if (!hold_same)              hold_cnt <= HW'(1);
        else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end
`else
  assign fast = 1'b0;
`endif

  // ------------------------------------------------------------- next value
  logic [WIDTH-1:0] ch_q [NCH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   cur_x;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  // One extra bit keeps value+step from overflowing before the bound compare.
  always_comb begin
    cur   = ch_q[ch_sel_i];
    cur_x = {1'b0, cur};
    step  = fast ? FAST_X : ONE_X;
    sum   = cur_x + step;
    nxt   = cur;
    if (up_i && !down_i) begin
      if (cur == MAX_W)     nxt = (WRAP != 0) ? MIN_W : MAX_W;
      else if (sum > MAX_X) nxt = MAX_W;
      else                  nxt = sum[WIDTH-1:0];
    end else if (down_i && !up_i) begin
      if (cur == MIN_W)              nxt = (WRAP != 0) ? MAX_W : MIN_W;
      else if (cur_x < MIN_X + step) nxt = MIN_W;
      else                           nxt = cur - step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) ch_q[k] <= RST_W;
    end else if (tick && single && sel_ok) begin
      ch_q[ch_sel_i] <= nxt;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign sel_value_o = sel_ok ? cur : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign value_o[k*WIDTH +: WIDTH] = ch_q[k];
    assign at_max_o[k]               = (ch_q[k] == MAX_W);
    assign at_min_o[k]               = (ch_q[k] == MIN_W);
  end

endmodule

// File: tb/tb_ref_setpoint_ctrl.sv
// Bench for ref_setpoint_ctrl: a saturating and a wrapping instance share all inputs.
// The driver pushes the reference model's expected channel state on every tick;
// a monitor pops and compares one cycle after each tick. Holds on HOLD_ACCEL_EN too.
module tb_ref_setpoint_ctrl;
  localparam int NCH  = 4;
  localparam int W    = 4;
  localparam int MINV = 0;
  localparam int MAXV = 9;
  localparam int RSTV = 0;
  localparam int DIV  = 4;
  localparam int HT   = 4;
  localparam int FS   = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         up = 1'b0;
  logic         dn = 1'b0;
  logic [1:0]   sel = '0;
  logic [15:0]  v_s, v_w;
  logic [3:0]   sv_s, sv_w;
  logic         tick_s, tick_w;
  logic [3:0]   amax_s, amin_s, amax_w, amin_w;

  always #5 clk = ~clk;

  ref_setpoint_ctrl #(.NCH(NCH), .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RST_VAL(RSTV),
                      .DIV(DIV), .WRAP(0), .HOLD_TICKS(HT), .FAST_STEP(FS)) u_sat (
    .clk_i(clk), .reset(reset), .up_i(up), .down_i(dn), .ch_sel_i(sel),
    .value_o(v_s), .sel_value_o(sv_s), .tick_o(tick_s), .at_max_o(amax_s), .at_min_o(amin_s));

  ref_setpoint_ctrl #(.NCH(NCH), .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RST_VAL(RSTV),
                      .DIV(DIV), .WRAP(1), .HOLD_TICKS(HT), .FAST_STEP(FS)) u_wrap (
    .clk_i(clk), .reset(reset), .up_i(up), .down_i(dn), .ch_sel_i(sel),
    .value_o(v_w), .sel_value_o(sv_w), .tick_o(tick_w), .at_max_o(amax_w), .at_min_o(amin_w));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------ reference model
  int ms[NCH];   // saturating instance
  int mw[NCH];   // wrapping instance
  int hold_n, hold_dir, hold_sel;

  function automatic int nv(input int v, input int dir, input int step, input bit wrap);
    if (dir > 0) begin
      if (v == MAXV) return wrap ? MINV : MAXV;
      return (v + step > MAXV) ? MAXV : v + step;
    end
    if (v == MINV) return wrap ? MAXV : MINV;
    return (v - step < MINV) ? MINV : v - step;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      ms[k] = RSTV;
      mw[k] = RSTV;
    end
    hold_n = 0; hold_dir = 0; hold_sel = 0;
  endtask

  // Run-length view of the held button: ticks at or past HT in a run use the fast step.
  task automatic model_tick(input bit u, input bit d, input int s);
    int dir, step;
    bit fast;
    fast = 1'b0;
    if (u != d) begin
      dir = u ? 1 : -1;
`ifdef HOLD_ACCEL_EN
      if (hold_n > 0 && dir == hold_dir && s == hold_sel) begin
        fast = (hold_n >= HT);
        if (hold_n < HT) hold_n++;
      end else begin
        hold_n = 1; hold_dir = dir; hold_sel = s;
      end
`endif
      step = fast ? FS : 1;
      if (s < NCH) begin
        ms[s] = nv(ms[s], dir, step, 1'b0);
        mw[s] = nv(mw[s], dir, step, 1'b1);
      end
    end else begin
      hold_n = 0;
    end
  endtask

  // --------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic [15:0] s;
    logic [15:0] w;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   pending = 1'b0;

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      e.s[k*W +: W] = W'(ms[k]);
      e.w[k*W +: W] = W'(mw[k]);
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (pending) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", 0, 1);
      end else begin
        logic [3:0] emax_s, emin_s, emax_w, emin_w;
        mon_e = q.pop_front();
        for (int k = 0; k < NCH; k++) begin
          emax_s[k] = (int'(mon_e.s[k*W +: W]) == MAXV);
          emin_s[k] = (int'(mon_e.s[k*W +: W]) == MINV);
          emax_w[k] = (int'(mon_e.w[k*W +: W]) == MAXV);
          emin_w[k] = (int'(mon_e.w[k*W +: W]) == MINV);
        end
        check("sat_value",  int'(v_s), int'(mon_e.s));
        check("wrap_value", int'(v_w), int'(mon_e.w));
        check("sat_at_max", int'(amax_s), int'(emax_s));
        check("sat_at_min", int'(amin_s), int'(emin_s));
        check("wrap_at_max", int'(amax_w), int'(emax_w));
        check("wrap_at_min", int'(amin_w), int'(emin_w));
        check("tick_align", int'(tick_w), int'(tick_s));
      end
    end
    pending = tick_s && !reset;
  end

  // ------------------------------------------------------------------ driver
  // Present inputs, wait for the tick, update the model, return just after the update edge.
  task automatic do_tick(input bit u, input bit d, input int s);
    int n;
    up = u; dn = d; sel = 2'(s);
    n = 0;
    @(negedge clk);
    while (!tick_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tick_s) begin
      check("tick_timeout", 0, 1);
    end else begin
      check("sat_sel_value", int'(sv_s), ms[s]);
      check("wrap_sel_value", int'(sv_w), mw[s]);
      model_tick(u, d, s);
      push_exp();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    up = 1'b0; dn = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_value_sat", int'(v_s), 0);
    check("rst_value_wrap", int'(v_w), 0);
    check("rst_tick", int'(tick_s), 0);
    check("rst_at_min", int'(amin_s), 15);
    check("rst_at_max", int'(amax_s), 0);
    reset = 1'b0;
  endtask

  // Step one channel to a target with releases in between so every step is 1.
  task automatic preset(input int ch, input int val);
    int guard;
    guard = 0;
    while (ms[ch] != val && guard < 40) begin
      do_tick(ms[ch] < val, ms[ch] > val, ch);
      do_tick(1'b0, 1'b0, ch);
      guard++;
    end
    check("preset_reached", ms[ch], val);
  endtask

`ifdef HOLD_ACCEL_EN
  int exp37[6] = '{1, 2, 3, 4, 7, 9};
  int exp38_1  = 7;
`else
  int exp37[6] = '{1, 2, 3, 4, 5, 6};
  int exp38_1  = 5;
`endif

  initial begin
    time t1, t2;
    int  n;
    bit  ru, rd;
    int  rs;

    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    bit  ru, rd;
    int  rs, n;

    model_reset();
    do_reset();

    // Three up ticks on channel 1, then tick spacing.
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0, 1);
    check("up3_ch1", int'(v_s[7:4]), 3);
    check("up3_others", int'({v_s[15:8], v_s[3:0]}), 0);
    do_tick(1'b0, 1'b0, 0);
    t1 = $time;
    do_tick(1'b0, 1'b0, 0);
    t2 = $time;
    check("tick_period", int'((t2 - t1) / 10), DIV);

    // Bound behaviour on channel 2 at MAX.
    do_reset();
    preset(2, 9);
    do_tick(1'b1, 1'b0, 2);
    check("max_sat_hold", int'(v_s[11:8]), 9);
    check("max_flag", int'(amax_s[2]), 1);
    check("max_wrap_0", int'(v_w[11:8]), 0);
    do_tick(1'b1, 1'b0, 2);
    check("max_sat_hold2", int'(v_s[11:8]), 9);
    check("max_wrap_1", int'(v_w[11:8]), 1);

    // Down at MIN on channel 3.
    do_tick(1'b0, 1'b1, 3);
    check("min_sat", int'(v_s[15:12]), 0);
    check("min_wrap", int'(v_w[15:12]), 9);

    // Both buttons pressed.
    do_reset();
    preset(0, 5);
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 0);
    check("both_pressed", int'(v_s[3:0]), 5);

    // Reset coincident with a tick carrying an up request.
    preset(3, 7);
    up = 1'b1; dn = 1'b0; sel = 2'd3;
    n = 0;
    while (!tick_s && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("found_tick", int'(tick_s), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    up = 1'b0;
    model_reset();
    t1 = $time;
    check("rst_tick_ch3", int'(v_s[15:12]), 0);
    check("rst_tick_low", int'(tick_s), 0);
    do_tick(1'b0, 1'b0, 0);
    check("prescaler_restart", int'(($time - t1) / 10), DIV);

    // Held up on channel 0, then release and step down.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_tick(1'b1, 1'b0, 0);
      check("hold_seq", int'(v_s[3:0]), exp37[i]);
    end
    do_tick(1'b0, 1'b0, 0);
    do_tick(1'b0, 1'b1, 0);
    check("after_release", int'(v_s[3:0]), exp37[5] - 1);

    // Channel switch in the middle of a hold.
    do_reset();
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0, 1);
    do_tick(1'b1, 1'b0, 2);
    do_tick(1'b1, 1'b0, 2);
    check("switch_ch1", int'(v_s[7:4]), exp38_1);
    check("switch_ch2", int'(v_s[11:8]), 2);

    // Randomized traffic, with frequent repeats so runs of held input occur.
    ru = 1'b0; rd = 1'b0; rs = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ru = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        rs = int'($urandom_range(0, 3));
      end
      do_tick(ru, rd, rs);
    end

    do_tick(1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
